// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: latches one load/store, waits LATENCY edges,
// then commits the access and pulses ready for one cycle with an alignment verdict.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  SaveMethod,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ready,
  output logic        misaligned
);
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic        wr;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] d;
  } req_t;

  state_t                           r_state;
  logic [CW-1:0]                    r_cnt;
  req_t                             r_req;
  logic [DEPTH_WORDS-1:0][31:0]     r_mem;

  req_t          w_req_in, w_cur;
  logic          w_commit, w_mis, w_unused;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [AW-1:0] w_idx;

  assign w_req_in = '{wr: MemWrite, sz: SaveMethod, a: addr, d: data_in};
  // With LATENCY=1 the commit happens on the accepting edge, so it must see the live request.
  assign w_cur    = (r_state == IDLE) ? w_req_in : r_req;
  assign w_commit = ((r_state == IDLE) && (LATENCY == 1) && (MemRead || MemWrite)) ||
                    ((r_state == WAIT) && (r_cnt == '0));
  assign w_idx    = w_cur.a[AW+1:2];
  assign w_unused = ^w_cur.a[31:AW+2];

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = w_cur.d;
    w_mis   = |w_cur.a[1:0];
    if (w_cur.wr) begin
      case (w_cur.sz)
        2'b00: begin
          w_be    = 4'b0001 << w_cur.a[1:0];
          w_wdata = {4{w_cur.d[7:0]}};
          w_mis   = 1'b0;
        end
        2'b01: begin
          w_be    = w_cur.a[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{w_cur.d[15:0]}};
          w_mis   = w_cur.a[0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_req      <= '0;
      r_mem      <= '0;
      data_out   <= '0;
      ready      <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (MemRead || MemWrite) begin
          r_req <= w_req_in;
          if (LATENCY == 1) r_state <= RESP;
          else begin
            r_state <= WAIT;
            r_cnt   <= CW'(LATENCY - 2);
          end
        end
        WAIT: if (r_cnt == '0) r_state <= RESP;
              else r_cnt <= r_cnt - CW'(1);
        RESP: begin
          r_state    <= IDLE;
          ready      <= 1'b0;
          misaligned <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
      if (w_commit) begin
        ready      <= 1'b1;
        misaligned <= w_mis;
        if (!w_mis) begin
          if (w_cur.wr) begin
            for (int i = 0; i < 4; i++)
              if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
          end else begin
            data_out <= r_mem[w_idx];
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed + random bench for data_mem_responder against a byte-addressed memory model.
module tb_data_mem_responder;
  localparam int DEPTH = 64;
  localparam int NB    = DEPTH * 4;

  logic        clk = 1'b0, rst = 1'b0;
  logic        MemRead = 1'b0, MemWrite = 1'b0;
  logic [1:0]  SaveMethod = 2'b00;
  logic [31:0] addr = '0, data_in = '0;
  logic [31:0] data_out;
  logic        ready, misaligned;

  int errors = 0, checks = 0;
  logic [7:0]  mbytes [NB];
  logic [31:0] exp_dout = '0;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
    .SaveMethod(SaveMethod), .addr(addr), .data_in(data_in),
    .data_out(data_out), .ready(ready), .misaligned(misaligned));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NB; i++) mbytes[i] = 8'h00;
    exp_dout = '0;
  endtask

  function automatic logic [31:0] model_word(input logic [31:0] a);
    int b;
    b = int'(a % NB) & ~3;
    return {mbytes[b+3], mbytes[b+2], mbytes[b+1], mbytes[b]};
  endfunction

  // Apply the architectural rules; returns expected misaligned flag.
  function automatic logic model_access(input bit wr, input logic [1:0] sz,
                                        input logic [31:0] a, input logic [31:0] d);
    int n, base;
    if (wr) begin
      n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      if ((a % n) != 0) return 1'b1;
      base = int'(a % NB);
      for (int k = 0; k < n; k++) mbytes[base + k] = d[8*k +: 8];
      return 1'b0;
    end
    if ((a % 4) != 0) return 1'b1;
    exp_dout = model_word(a);
    return 1'b0;
  endfunction

  // Request held across acceptance edge only; inputs scrambled afterwards.
  task automatic access(input bit rd, input bit wr, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] d, input string tag);
    logic exp_mis;
    exp_mis = model_access(wr, sz, a, d);
    @(negedge clk);
    MemRead = rd; MemWrite = wr; SaveMethod = sz; addr = a; data_in = d;
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0; addr = $urandom; data_in = $urandom;
    SaveMethod = 2'($urandom);
    chk({tag, "_rdy_early"}, {31'b0, ready}, 32'd0);
    @(posedge clk); #1;
    chk({tag, "_rdy"}, {31'b0, ready}, 32'd1);
    chk({tag, "_mis"}, {31'b0, misaligned}, {31'b0, exp_mis});
    chk({tag, "_dout"}, data_out, exp_dout);
    @(posedge clk); #1;
    chk({tag, "_rdy_clr"}, {31'b0, ready}, 32'd0);
    chk({tag, "_mis_clr"}, {31'b0, misaligned}, 32'd0);
  endtask

  initial begin
    int pulses [$];
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, ready}, 32'd0);
    chk("rst_mis", {31'b0, misaligned}, 32'd0);
    chk("rst_dout", data_out, 32'd0);
    @(negedge clk); rst = 1'b1;

    access(1, 0, 2'b10, 32'h10, 32'h0, "ld10");
    access(0, 1, 2'b10, 32'h08, 32'hDEADBEEF, "st_word");
    access(1, 0, 2'b10, 32'h08, 32'h0, "ld_word");
    chk("ld_word_const", data_out, 32'hDEADBEEF);
    access(0, 1, 2'b00, 32'h09, 32'hFFFFFF11, "st_byte");
    access(0, 1, 2'b01, 32'h0A, 32'hFFFF2233, "st_half");
    access(1, 0, 2'b10, 32'h08, 32'h0, "ld_merge");
    chk("merge_const", data_out, 32'h223311EF);

    access(0, 1, 2'b10, 32'h0C, 32'h12345678, "st_0c");
    access(0, 1, 2'b10, 32'h0D, 32'h00000055, "mis_word");
    access(0, 1, 2'b01, 32'h0B, 32'h0000AAAA, "mis_half");
    access(1, 0, 2'b10, 32'h0E, 32'h0, "mis_load");
    access(1, 0, 2'b10, 32'h0C, 32'h0, "ld_0c");
    chk("ld_0c_const", data_out, 32'h12345678);

    // Held load: accepted every LATENCY+1 cycles.
    @(negedge clk);
    MemRead = 1'b1; MemWrite = 1'b0; addr = 32'h08;
    for (int c = 0; c < 9; c++) begin
      @(posedge clk); #1;
      if (ready) begin
        pulses.push_back(c);
        chk("hold_dout", data_out, 32'h223311EF);
      end
    end
    @(negedge clk); MemRead = 1'b0;
    exp_dout = 32'h223311EF;
    chk("hold_count", pulses.size(), 32'd3);
    if (pulses.size() == 3) begin
      chk("hold_first", pulses[0], 32'd1);
      chk("hold_gap1", pulses[1] - pulses[0], 32'd3);
      chk("hold_gap2", pulses[2] - pulses[1], 32'd3);
    end

    // Reset during WAIT aborts the store and clears memory.
    @(negedge clk);
    MemWrite = 1'b1; SaveMethod = 2'b10; addr = 32'h20; data_in = 32'hCAFEF00D;
    @(posedge clk); #1;
    MemWrite = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rstw_ready", {31'b0, ready}, 32'd0);
    chk("rstw_dout", data_out, 32'd0);
    @(posedge clk); #1;
    chk("rstw_ready2", {31'b0, ready}, 32'd0);
    @(negedge clk); rst = 1'b1;
    model_clear();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("rstw_noready", {31'b0, ready}, 32'd0);
    end
    access(1, 0, 2'b10, 32'h20, 32'h0, "ld20");
    access(1, 0, 2'b10, 32'h08, 32'h0, "ld08_clr");

    // Random mix; addresses span twice the depth to exercise wrap.
    for (int t = 0; t < 60; t++) begin
      int mode;
      logic [31:0] a, d;
      mode = $urandom_range(0, 2);
      a = (t % 2 == 0) ? 32'($urandom_range(0, 2*NB - 1)) : $urandom;
      d = $urandom;
      case (mode)
        0: access(1, 0, 2'($urandom), a, d, "rnd_ld");
        1: access(0, 1, 2'($urandom), a, d, "rnd_st");
        default: access(1, 1, 2'($urandom), a, d, "rnd_both");
      endcase
    end
    for (int w = 0; w < 8; w++)
      access(1, 0, 2'b10, 32'(w * 4), 32'h0, "rnd_sweep");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
